// File: rtl/bd_out_handshaker.sv
// Takes words from the core BD_out channel and presents them to Braindrop on a
// bundled-data 4-phase port: data is held for a setup time, then req/ack completes.
module bd_out_handshaker #(
    parameter int NBDdata  = 21,
    parameter int Nsetup   = 2,
    parameter int Nsync    = 2,
    parameter int Ntimeout = 16,
    parameter int Ncount   = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NBDdata-1:0] in_d,
    input  logic               in_v,
    output logic               in_a,
    output logic [NBDdata-1:0] bd_data,
    output logic               bd_req,
    input  logic               bd_ack,
    input  logic               hold,
    output logic               busy,
    output logic               timeout_err,
    output logic [Ncount-1:0]  sent_count
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] SETUP   = 2'd1;
    localparam logic [1:0] WAIT_HI = 2'd2;
    localparam logic [1:0] WAIT_LO = 2'd3;

    localparam logic [3:0]          SETUP_LOAD = 4'(Nsetup);
    localparam logic [Ntimeout-1:0] WAIT_MAX   = '1;

    logic [1:0]          state;
    logic [Nsync-1:0]    ack_sync;
    logic                ack_s;
    logic [3:0]          setup_cnt;
    logic [Ntimeout-1:0] wait_cnt;
    logic [Ntimeout-1:0] wait_inc;
    logic                xfer;

    // bd_ack is asynchronous to clk; only the last flop of this chain is trusted
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ack_sync <= '0;
        end else begin
            ack_sync <= {ack_sync[Nsync-2:0], bd_ack};
        end
    end

    assign ack_s    = ack_sync[Nsync-1];
    assign in_a     = (state == IDLE) && !hold && !ack_s;
    assign xfer     = in_a && in_v;
    assign busy     = (state != IDLE);
    assign wait_inc = (wait_cnt == WAIT_MAX) ? wait_cnt : wait_cnt + 1'b1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            bd_data     <= '0;
            bd_req      <= 1'b0;
            setup_cnt   <= '0;
            wait_cnt    <= '0;
            timeout_err <= 1'b0;
            sent_count  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (xfer) begin
                        bd_data   <= in_d;
                        setup_cnt <= SETUP_LOAD;
                        state     <= SETUP;
                    end
                end
                SETUP: begin
                    setup_cnt <= setup_cnt - 1'b1;
                    if (setup_cnt == 4'd1) begin
                        bd_req   <= 1'b1;
                        wait_cnt <= '0;
                        state    <= WAIT_HI;
                    end
                end
                WAIT_HI: begin
                    if (ack_s) begin
                        bd_req   <= 1'b0;
                        wait_cnt <= '0;
                        state    <= WAIT_LO;
                    end else begin
                        wait_cnt <= wait_inc;
                        if (wait_inc == WAIT_MAX) begin
                            timeout_err <= 1'b1;
                        end
                    end
                end
                WAIT_LO: begin
                    // A stuck ack only raises the flag; the word is never abandoned
                    if (!ack_s) begin
                        sent_count <= sent_count + 1'b1;
                        state      <= IDLE;
                    end else begin
                        wait_cnt <= wait_inc;
                        if (wait_inc == WAIT_MAX) begin
                            timeout_err <= 1'b1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bd_out_handshaker.sv
// Bench for bd_out_handshaker: a BD responder drives bd_ack, and a transaction-level
// timing model predicts every output at each falling clock edge.
module tb_bd_out_handshaker;

    localparam int NBD      = 21;
    localparam int NSETUP   = 2;
    localparam int NSYNC    = 2;
    localparam int NTIMEOUT = 8;
    localparam int NCOUNT   = 16;
    localparam int TMAX     = (1 << NTIMEOUT) - 1;

    logic              clk;
    logic              reset;
    logic [NBD-1:0]    in_d;
    logic              in_v;
    logic              in_a;
    logic [NBD-1:0]    bd_data;
    logic              bd_req;
    logic              bd_ack;
    logic              hold;
    logic              busy;
    logic              timeout_err;
    logic [NCOUNT-1:0] sent_count;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic bd_manual     = 1'b0;
    logic bd_manual_val = 1'b0;
    int   rise_dly      = 3;
    int   fall_dly      = 3;
    int   bd_hi         = 0;
    int   bd_lo         = 0;

    bit             have_txn;
    int             xfer_edge;
    int             req_rise;
    int             req_fall;
    int             done_edge;
    int             model_sent;
    logic [NBD-1:0] exp_data;
    logic           exp_tout;
    logic           prev_ack;
    logic           ackq[$];
    logic [NBD-1:0] words[$];

    bd_out_handshaker #(
        .NBDdata (NBD),
        .Nsetup  (NSETUP),
        .Nsync   (NSYNC),
        .Ntimeout(NTIMEOUT),
        .Ncount  (NCOUNT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .in_d       (in_d),
        .in_v       (in_v),
        .in_a       (in_a),
        .bd_data    (bd_data),
        .bd_req     (bd_req),
        .bd_ack     (bd_ack),
        .hold       (hold),
        .busy       (busy),
        .timeout_err(timeout_err),
        .sent_count (sent_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h cyc=%0d", tag, obs, exp, cyc);
        end
    endtask

    // BD responder: raises ack rise_dly samples after req, drops it fall_dly samples after req falls
    initial begin
        bd_ack = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (bd_manual) begin
                bd_ack = bd_manual_val;
                bd_hi  = 0;
                bd_lo  = 0;
            end else if (!bd_ack) begin
                bd_lo = 0;
                bd_hi = bd_req ? bd_hi + 1 : 0;
                if (bd_hi >= rise_dly) begin
                    bd_ack = 1'b1;
                    bd_hi  = 0;
                end
            end else begin
                bd_hi = 0;
                bd_lo = !bd_req ? bd_lo + 1 : 0;
                if (bd_lo >= fall_dly) begin
                    bd_ack = 1'b0;
                    bd_lo  = 0;
                end
            end
        end
    end

    // Timing model: an ack change seen after edge c reaches the FSM at edge c+NSYNC+1
    initial begin
        logic exp_ack_s, exp_busy, exp_req, exp_in_a;
        int c;
        prev_ack = 1'b0;
        forever begin
            @(negedge clk);
            c = cyc;
            if (!reset) begin
                have_txn   = 0;
                model_sent = 0;
                exp_data   = '0;
                exp_tout   = 1'b0;
                words.delete();
                ackq.delete();
                for (int i = 0; i < NSYNC; i++) ackq.push_back(1'b0);
            end else begin
                exp_ack_s = ackq[0];
                if (bd_ack && !prev_ack && have_txn && req_fall < 0 && c >= req_rise)
                    req_fall = c + NSYNC + 1;
                if (!bd_ack && prev_ack && have_txn && req_fall >= 0 && done_edge < 0)
                    done_edge = c + NSYNC + 1;
                if (have_txn && c == xfer_edge) exp_data = words.pop_front();
                if (have_txn && done_edge >= 0 && c >= done_edge) begin
                    have_txn = 0;
                    model_sent++;
                end
                exp_busy = have_txn && (c >= xfer_edge);
                exp_req  = have_txn && (c >= req_rise) && (req_fall < 0 || c < req_fall);
                if (exp_req && (c - req_rise) >= TMAX) exp_tout = 1'b1;
                exp_in_a = !exp_busy && !hold && !exp_ack_s;

                check_output("busy", busy, exp_busy);
                check_output("bd_req", bd_req, exp_req);
                check_output("bd_data", bd_data, exp_data);
                check_output("in_a", in_a, exp_in_a);
                check_output("sent_count", sent_count, model_sent[NCOUNT-1:0]);
                check_output("timeout_err", timeout_err, exp_tout);

                if (in_v && exp_in_a) begin
                    words.push_back(in_d);
                    have_txn  = 1;
                    xfer_edge = c + 1;
                    req_rise  = c + 1 + NSETUP;
                    req_fall  = -1;
                    done_edge = -1;
                end
                void'(ackq.pop_front());
                ackq.push_back(bd_ack);
            end
            prev_ack = bd_ack;
        end
    end

    // Presents a word and returns just after the edge that accepts it
    task automatic apply_word(input logic [NBD-1:0] w);
        bit ok = 0;
        in_d = w;
        in_v = 1'b1;
        for (int i = 0; i < 400 && !ok; i++) begin
            @(negedge clk);
            if (in_a) ok = 1;
        end
        check_output("accept_wait", ok, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input int limit);
        bit ok = 0;
        for (int i = 0; i < limit && !ok; i++) begin
            @(negedge clk);
            if (!busy && !bd_ack) ok = 1;
        end
        check_output("idle_wait", ok, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_req(input logic level, input int limit);
        bit ok = 0;
        for (int i = 0; i < limit && !ok; i++) begin
            @(negedge clk);
            if (bd_req == level) ok = 1;
        end
        check_output("req_wait", ok, 1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [NBD-1:0] w;
        reset = 1'b0;
        hold  = 1'b0;
        in_v  = 1'b0;
        in_d  = '0;
        #2;
        check_output("rst_bd_data", bd_data, 0);
        check_output("rst_bd_req", bd_req, 0);
        check_output("rst_busy", busy, 0);
        check_output("rst_timeout", timeout_err, 0);
        check_output("rst_sent", sent_count, 0);
        check_output("rst_in_a", in_a, 1);
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;

        // Single word with a 3-cycle BD response
        rise_dly = 3;
        fall_dly = 3;
        apply_word(21'h1ABCD);
        in_v = 1'b0;
        wait_idle(100);
        check_output("t1_sent", sent_count, 1);

        // Back-to-back words with valid held high
        apply_word(21'h00001);
        apply_word(21'h1FFFF);
        apply_word(21'h0AAAA);
        in_v = 1'b0;
        wait_idle(100);
        check_output("t2_sent", sent_count, 4);

        // hold raised mid-transaction: current word finishes, next one waits
        apply_word(21'h12345);
        in_d = 21'h054321;
        wait_req(1'b1, 50);
        hold = 1'b1;
        wait_idle(100);
        repeat (5) @(posedge clk);
        #1;
        check_output("t3_in_a_held", in_a, 0);
        check_output("t3_sent", sent_count, 5);
        hold = 1'b0;
        @(posedge clk);
        #1;
        check_output("t3_busy_after_release", busy, 1);
        in_v = 1'b0;
        wait_idle(100);
        check_output("t3_sent2", sent_count, 6);

        // Randomized words and BD response times
        for (int k = 0; k < 6; k++) begin
            rise_dly = $urandom_range(1, 5);
            fall_dly = $urandom_range(1, 5);
            w = NBD'($urandom);
            apply_word(w);
            in_v = 1'b0;
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
            wait_idle(100);
        end
        check_output("rand_sent", sent_count, 12);

        // Reset while BD still holds ack; nothing accepted until the ack falls
        hold          = 1'b1;
        bd_manual_val = 1'b1;
        bd_manual     = 1'b1;
        repeat (4) @(posedge clk);
        #3 reset = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        hold = 1'b0;
        in_d = 21'h0F0F0;
        in_v = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check_output("t4_in_a_ack_high", in_a, 0);
        check_output("t4_busy", busy, 0);
        bd_manual_val = 1'b0;
        apply_word(21'h0F0F0);
        in_v      = 1'b0;
        bd_manual = 1'b0;
        wait_idle(100);
        check_output("t4_sent", sent_count, 1);

        // BD never acks: timeout flags but the word is still delivered once ack arrives
        bd_manual_val = 1'b0;
        bd_manual     = 1'b1;
        apply_word(21'h13579);
        in_v = 1'b0;
        wait_req(1'b1, 20);
        repeat (260) @(posedge clk);
        #1;
        check_output("t5_timeout", timeout_err, 1);
        check_output("t5_req_held", bd_req, 1);
        bd_manual_val = 1'b1;
        wait_req(1'b0, 20);
        bd_manual_val = 1'b0;
        wait_idle(50);
        bd_manual = 1'b0;
        check_output("t5_sent", sent_count, 2);
        check_output("t5_timeout_sticky", timeout_err, 1);

        // Asynchronous reset between edges while waiting for ack
        rise_dly = 12;
        apply_word(NBD'($urandom) | 21'h1);
        in_v = 1'b0;
        wait_req(1'b1, 20);
        check_output("t6_req_before", bd_req, 1);
        @(posedge clk);
        #3 reset = 1'b0;
        #1;
        check_output("t6_bd_req", bd_req, 0);
        check_output("t6_bd_data", bd_data, 0);
        check_output("t6_busy", busy, 0);
        check_output("t6_sent", sent_count, 0);
        check_output("t6_timeout", timeout_err, 0);
        @(posedge clk);
        #1 reset = 1'b1;
        rise_dly = 2;
        apply_word(21'h0BEEF);
        in_v = 1'b0;
        wait_idle(100);
        check_output("t6_sent_after", sent_count, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bd_out_handshaker.md
Name: bd_out_handshaker

Overview:
- Downstream of the core's BD-bound output FIFO. Consumes encoded BD words over a Channel (d/v/a).
- Drives the Braindrop chip's bundled-data, 4-phase input port: data bus, req out, ack in.
- Latches each word, holds data for a programmable setup time, then raises req and completes the full req/ack cycle before accepting the next word.
- Synchronizes the asynchronous ack, flags a stuck handshake, and counts delivered words.

Parameters:
- NBDdata, 21, width of encoded BD word (matches core BD_out width)
- Nsetup, 2, cycles data is stable before req rises (legal range 1..15)
- Nsync, 2, ack synchronizer depth in flops (legal range 2..4)
- Ntimeout, 16, width of ack-wait counter; timeout fires at 2^Ntimeout-1 cycles
- Ncount, 16, width of delivered-word counter

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- in.d  in  NBDdata  word from core BD_out channel
- in.v  in  1  channel valid
- in.a  out  1  channel accept; transfer occurs on a clk edge with in.v && in.a
- bd_data  out  NBDdata  bundled data to BD
- bd_req  out  1  4-phase request to BD
- bd_ack  in  1  4-phase acknowledge from BD (asynchronous to clk)
- hold  in  1  when high, no new word is accepted (driven by core pReset)
- busy  out  1  high whenever state != IDLE
- timeout_err  out  1  sticky; ack wait exceeded limit
- sent_count  out  Ncount  completed transactions, wraps modulo 2^Ncount

Behaviour:
- Reset values: bd_data=0, bd_req=0, busy=0, timeout_err=0, sent_count=0, state=IDLE, all synchronizer flops=0. Reset acts immediately, without waiting for a clk edge, including mid-transaction.
- ack_s is bd_ack passed through Nsync flops; the FSM uses only ack_s.
- in.a = (state==IDLE) && !hold && !ack_s. This is combinational from registered state and does not depend on in.v.
- State IDLE:
  - On transfer: bd_data<=in.d, setup_cnt<=Nsetup, go to SETUP.
  - If ack_s==1 in IDLE (BD still completing from before reset), stay in IDLE and accept nothing until ack_s==0.
- State SETUP:
  - Each cycle setup_cnt decrements.
  - On the edge where setup_cnt==1: bd_req<=1, wait_cnt<=0, go to WAIT_HI.
  - Net effect: bd_req rises exactly Nsetup edges after the transfer edge.
- State WAIT_HI:
  - When ack_s==1: bd_req<=0, wait_cnt<=0, go to WAIT_LO.
  - Otherwise wait_cnt increments, saturating at all-ones.
- State WAIT_LO:
  - When ack_s==0: sent_count<=sent_count+1, go to IDLE.
  - Otherwise wait_cnt increments, saturating.
- Timeout: in WAIT_HI or WAIT_LO, when wait_cnt reaches 2^Ntimeout-1, timeout_err<=1.
  - timeout_err is sticky until reset.
  - The FSM keeps waiting; the word is never dropped or retransmitted.
- bd_data is stable from the transfer edge until the next transfer. It never changes while bd_req==1 or while ack_s==1.
- hold:
  - Sampled only in IDLE, via in.a.
  - An in-flight transaction always completes regardless of hold.
  - Asserting hold on the same edge as a transfer does not cancel that transfer.
- Throughput: minimum cycles per word = 1 + Nsetup + 2*Nsync + BD response time. No pipelining across words.
- Word order is strictly preserved. There is no internal buffering beyond one word register.

Test Plan:
1. Nsetup=2, Nsync=2; drive in.d=0x1ABCD, in.v=1 at edge T0; BD model raises ack 3 cycles after req, drops it 3 cycles after req falls.
   - Expect bd_data=0x1ABCD from T0, bd_req high at T2.
   - Expect in.a=0 from T0 until return to IDLE; sent_count=1.
2. Back-to-back words 0x00001, 0x1FFFF, 0x0AAAA with in.v held high.
   - Expect three complete 4-phase cycles in order.
   - bd_data never changes while bd_req=1 or ack_s=1; sent_count=3.
3. hold=1 while a word is in WAIT_HI.
   - Expect the current transaction to finish (sent_count+1), then in.a=0 with in.v=1 pending.
   - Release hold: word accepted on the next edge.
4. Assert reset with bd_ack=1 held by the BD model, then release reset.
   - Expect in.a=0 until bd_ack falls; in.a=1 exactly Nsync edges after the fall.
5. Ntimeout=8, BD model never acks.
   - Expect timeout_err=1 when wait_cnt reaches 255 (255 edges after bd_req rises), bd_req stays 1.
   - A late ack then completes normally: sent_count=1, timeout_err remains 1.
6. Assert reset asynchronously between clk edges while in WAIT_HI.
   - Expect bd_req=0, bd_data=0, busy=0, sent_count=0 immediately, with no clk edge.
